mux_rr_sched: RTL and testbench

Round-robin scheduler that shares the 4-input, 2-bit key-selected mux between four requesters. It owns the mux select key and issues a one-hot grant with a programmable minimum dwell. When other requesters are waiting, it forces rotation once the dwell expires. It sits between the switch/requester logic and the mux, replacing the direct switch-to-key connection.

---
 rtl/mux_rr_sched.sv | 148 ++++++++++++++
 tb/tb_mux_rr_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin owner of the 4:1 mux select key with minimum dwell
//
// Purpose: arbitrates four level-sensitive requesters for the shared
// key-selected mux. The owner keeps the grant for at least dwell_cfg+1
// cycles when others are waiting, then rotation is forced. An owner that
// drops its request hands over in the same edge with no idle bubble.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   req        per-channel request levels
//   dwell_cfg  cycles after grant before preemption is allowed (0 = immediate)
//   grant      one-hot current owner, zero when idle
//   sel        mux key, index of the owner; holds last owner while idle
//   busy       high while a grant is active
//   switch_p   one-cycle pulse when a new owner's grant first appears

module mux_rr_sched #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell_cfg,
    output logic [3:0]         grant,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               switch_p
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               switch_q, switch_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Returns {found, index} of the first set bit of r scanning upward
    // from start, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic       found;
        logic [1:0] idx;
        dbl   = {r, r};
        rot   = dbl[start +: 4];
        found = 1'b0;
        idx   = 2'd0;
        // Descending loop so the lowest rotated position wins.
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = start + 2'(k);
            end
        end
        return {found, idx};
    endfunction

    logic [3:0] others;
    logic       owner_req;
    logic       expired;
    logic [2:0] idle_pick;
    logic [2:0] hand_pick;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        switch_d  = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        others    = req & ~grant_q;
        owner_req = |(req & grant_q);
        // Live compare: a dwell_cfg change applies on the very next edge.
        expired   = (cnt_q >= dwell_cfg);
        idle_pick = pick(req, ptr_q);
        hand_pick = pick(others, sel_q + 2'd1);

        case (state_q)
            S_IDLE: begin
                if (idle_pick[2]) begin
                    state_d  = S_GRANT;
                    grant_d  = 4'b0001 << idle_pick[1:0];
                    sel_d    = idle_pick[1:0];
                    busy_d   = 1'b1;
                    switch_d = 1'b1;
                    cnt_d    = '0;
                    ptr_d    = idle_pick[1:0] + 2'd1;
                end
            end
            S_GRANT: begin
                // Release and preemption share the same handover path, so a
                // simultaneous drop-and-expire gives the same result.
                if (hand_pick[2] && (!owner_req || expired)) begin
                    grant_d  = 4'b0001 << hand_pick[1:0];
                    sel_d    = hand_pick[1:0];
                    switch_d = 1'b1;
                    cnt_d    = '0;
                    ptr_d    = hand_pick[1:0] + 2'd1;
                end else if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end else if (cnt_q != {DWELL_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= 4'b0000;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            switch_q <= 1'b0;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            switch_q <= switch_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign switch_p = switch_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - scoreboard bench for mux_rr_sched

module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] dwell_cfg = 4'd0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       switch_p;

    mux_rr_sched #(.DWELL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dwell_cfg (dwell_cfg),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
        .switch_p  (switch_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       sw;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int sw_seen  = 0;

    // Reference model state
    int         m_busy  = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    int         m_sel   = 0;
    int         m_sw    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int scan(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [3:0] r, input int dw);
        int n;
        logic [3:0] oth;
        m_sw = 0;
        if (r_rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
        end else if (m_busy == 0) begin
            n = scan(r, m_ptr);
            if (n >= 0) begin
                m_busy = 1; m_owner = n; m_sel = n; m_sw = 1; m_cnt = 0;
                m_ptr = (n + 1) % 4;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (oth != 0 && (!r[m_owner] || m_cnt >= dw)) begin
                n = scan(oth, (m_owner + 1) % 4);
                m_owner = n; m_sel = n; m_sw = 1; m_cnt = 0;
                m_ptr = (n + 1) % 4;
            end else if (!r[m_owner]) begin
                m_busy = 0;
            end else if (m_cnt < 15) begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic r_rst, input logic [3:0] r_req, input logic [3:0] r_dw);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst       = r_rst;
        req       = r_req;
        dwell_cfg = r_dw;
        model_edge(r_rst, r_req, int'(r_dw));
        e.g  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        e.s  = 2'(m_sel);
        e.b  = (m_busy != 0);
        e.sw = (m_sw != 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check_eq("grant", 32'(grant), 32'(o.g));
        check_eq("sel", 32'(sel), 32'(o.s));
        check_eq("busy", 32'(busy), 32'(o.b));
        check_eq("switch_p", 32'(switch_p), 32'(o.sw));
        if (switch_p === 1'b1) sw_seen++;
    endtask

    initial begin
        // Reset with all requests asserted
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1111, 4'd2);
            check_eq("rst_grant", 32'(grant), 32'h0);
        end

        // Rotation with dwell 2: each owner holds for 3 cycles
        sw_seen = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 4'b1111, 4'd2);
            check_eq("rot_grant", 32'(grant), 32'(4'b0001 << ((i / 3) % 4)));
        end
        check_eq("rot_switches", 32'(sw_seen), 32'd5);

        // Single persistent requester, dwell 0
        step(1'b1, 4'b0000, 4'd0);
        sw_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0100, 4'd0);
            check_eq("solo_grant", 32'(grant), 32'h4);
        end
        check_eq("solo_switches", 32'(sw_seen), 32'd1);
        step(1'b0, 4'b0000, 4'd0);
        check_eq("solo_idle_grant", 32'(grant), 32'h0);
        check_eq("solo_idle_busy", 32'(busy), 32'h0);
        check_eq("solo_idle_sel", 32'(sel), 32'h2);

        // Idle-gap fairness: pointer is 3 after owner 2
        step(1'b0, 4'b1111, 4'd0);
        check_eq("gap_grant", 32'(grant), 32'h8);

        // Owner 1 releases with 0 and 3 pending
        step(1'b1, 4'b0000, 4'd7);
        step(1'b0, 4'b0010, 4'd7);
        check_eq("rel_own1", 32'(grant), 32'h2);
        step(1'b0, 4'b1011, 4'd7);
        step(1'b0, 4'b1001, 4'd7);
        check_eq("rel_next", 32'(grant), 32'h8);
        check_eq("rel_no_bubble", 32'(busy), 32'h1);

        // Saturation: long hold with dwell 15, then contention preempts
        step(1'b1, 4'b0000, 4'd15);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 4'd15);
        step(1'b0, 4'b0011, 4'd15);
        check_eq("sat_preempt", 32'(grant), 32'h2);

        // Live dwell drop from 7 to 1 with cnt at 4
        step(1'b1, 4'b0000, 4'd7);
        step(1'b0, 4'b0001, 4'd7);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0011, 4'd7);
            check_eq("dw_hold", 32'(grant), 32'h1);
        end
        step(1'b0, 4'b0011, 4'd1);
        check_eq("dw_preempt", 32'(grant), 32'h2);
        step(1'b0, 4'b0011, 4'd7);
        step(1'b1, 4'b0011, 4'd7);
        check_eq("mid_rst_grant", 32'(grant), 32'h0);
        check_eq("mid_rst_sel", 32'(sel), 32'h0);
        step(1'b0, 4'b1111, 4'd7);
        check_eq("post_rst_ptr", 32'(grant), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
